// File: rtl/vector_lane_alu_seq_if.sv
// rtl/vector_lane_alu_seq_if.sv - issue/result bundle between operand fetch, vector execute and writeback
interface vector_lane_alu_seq_if #(
  parameter int N = 16
);
  logic                  start;
  logic [2:0]            op;
  logic                  use_imm;
  logic [15:0][N-1:0]    src_a;
  logic [15:0][N-1:0]    src_b;
  logic [15:0][N-1:0]    imm_ext;
  logic                  busy;
  logic                  done;
  logic [15:0][N-1:0]    result;

  modport master (
    output start, op, use_imm, src_a, src_b, imm_ext,
    input  busy, done, result
  );

  modport slave (
    input  start, op, use_imm, src_a, src_b, imm_ext,
    output busy, done, result
  );
endinterface

// File: rtl/vector_lane_alu_seq.sv
// rtl/vector_lane_alu_seq.sv - multi-cycle 16-lane vector ALU sharing LPB lane ALUs across beats
module vector_lane_alu_seq #(
  parameter int N   = 16,
  parameter int LPB = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  vector_lane_alu_seq_if.slave   bus
);
  localparam int NBEATS = 16 / LPB;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                state;
  logic [BW-1:0]         beat;
  logic [2:0]            op_q;
  logic [15:0][N-1:0]    a_q;
  logic [15:0][N-1:0]    b_q;
  logic [15:0][N-1:0]    staging;
  logic [15:0][N-1:0]    nxt;
  logic [15:0][N-1:0]    result_q;
  logic                  busy_q;
  logic                  done_q;
  logic [3:0]            idx;
  logic                  last_beat;

  function automatic logic [N-1:0] lane_op(input logic [2:0] o,
                                           input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    case (o)
      3'b000:  lane_op = a + b;
      3'b001:  lane_op = a - b;
      3'b010:  lane_op = a & b;
      3'b011:  lane_op = a | b;
      3'b100:  lane_op = a ^ b;
      3'b101:  lane_op = a << b[3:0];
      3'b110:  lane_op = a >> b[3:0];
      default: lane_op = b;
    endcase
  endfunction

  assign last_beat = (beat == BW'(NBEATS - 1));

  // The LPB ALUs are steered onto the lanes of the current beat; other lanes keep staged values.
  always_comb begin
    nxt = staging;
    idx = '0;
    for (int l = 0; l < LPB; l++) begin
      idx      = 4'(int'(beat) * LPB + l);
      nxt[idx] = lane_op(op_q, a_q[idx], b_q[idx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      staging  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.src_a;
            b_q    <= bus.use_imm ? bus.imm_ext : bus.src_b;
            op_q   <= bus.op;
            beat   <= '0;
            busy_q <= 1'b1;
            state  <= EXEC;
          end else begin
            state  <= IDLE;
          end
        end
        EXEC: begin
          staging <= nxt;
          if (last_beat) begin
            result_q <= nxt;
            beat     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            beat     <= beat + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_vector_lane_alu_seq.sv
// tb/tb_vector_lane_alu_seq.sv - directed-vector bench over LPB=4, LPB=1 and LPB=16 instances
module tb_vector_lane_alu_seq;
  typedef logic [15:0][15:0] vec_t;

  logic clk;
  logic rst_n;
  logic start;
  logic [2:0] op;
  logic use_imm;
  vec_t src_a, src_b, imm_ext;

  logic [2:0] busy_w, done_w;
  vec_t       res_w [3];

  int n_vec  = 0;
  int n_miss = 0;
  int nb [3] = '{4, 16, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int LPBK = (k == 0) ? 4 : (k == 1) ? 1 : 16;
    vector_lane_alu_seq_if #(.N(16)) bus ();
    assign bus.start   = start;
    assign bus.op      = op;
    assign bus.use_imm = use_imm;
    assign bus.src_a   = src_a;
    assign bus.src_b   = src_b;
    assign bus.imm_ext = imm_ext;
    assign busy_w[k]   = bus.busy;
    assign done_w[k]   = bus.done;
    assign res_w[k]    = bus.result;
    vector_lane_alu_seq #(.N(16), .LPB(LPBK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic check_vec(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t splat(input logic [15:0] v);
    vec_t r;
    for (int i = 0; i < 16; i++) r[i] = v;
    return r;
  endfunction

  // Issues one op, scrambles inputs after accept, then watches every instance for 20 cycles.
  task automatic run_op(input string tag, input logic [2:0] o, input logic ui,
                        input vec_t a, input vec_t b, input vec_t im, input vec_t exp);
    vec_t prev [3];
    vec_t got  [3];
    int   bc   [3];
    int   dc   [3];
    logic stable [3];
    for (int k = 0; k < 3; k++) begin
      prev[k] = res_w[k]; got[k] = '0; bc[k] = 0; dc[k] = 0; stable[k] = 1'b1;
    end
    op = o; use_imm = ui; src_a = a; src_b = b; imm_ext = im; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src_a = ~a; src_b = ~b; imm_ext = ~im; op = ~o; use_imm = ~ui;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (busy_w[k]) begin
          bc[k]++;
          if (res_w[k] !== prev[k]) stable[k] = 1'b0;
        end
        if (done_w[k]) begin
          dc[k]++;
          got[k] = res_w[k];
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      check_vec($sformatf("%s.lpb_nb%0d.busy_cycles", tag, nb[k]), bc[k], nb[k]);
      check_vec($sformatf("%s.lpb_nb%0d.done_count", tag, nb[k]), dc[k], 1);
      check_vec($sformatf("%s.lpb_nb%0d.result", tag, nb[k]), got[k], exp);
      check_vec($sformatf("%s.lpb_nb%0d.held_in_exec", tag, nb[k]), stable[k], 1'b1);
    end
  endtask

  initial begin
    vec_t a, exp;
    int   dones, busys;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; use_imm = 1'b0;
    src_a = '0; src_b = '0; imm_ext = '0;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_vec($sformatf("reset.busy%0d", k), busy_w[k], 1'b0);
      check_vec($sformatf("reset.done%0d", k), done_w[k], 1'b0);
      check_vec($sformatf("reset.result%0d", k), res_w[k], '0);
    end
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (done_w != 3'b000) dones++;
    end
    check_vec("idle.no_done", dones, 0);

    // Add with broadcast immediate
    for (int i = 0; i < 16; i++) begin
      a[i]   = 16'(i);
      exp[i] = 16'(i + 5);
    end
    run_op("add_imm", 3'b000, 1'b1, a, splat(16'h7777), splat(16'h0005), exp);

    // Wrap and lane isolation
    run_op("add_wrap", 3'b000, 1'b0, splat(16'hFFFF), splat(16'h0001), splat(16'h1111), splat(16'h0000));
    run_op("sub_wrap", 3'b001, 1'b0, splat(16'h0000), splat(16'h0001), splat(16'h1111), splat(16'hFFFF));

    // Logic, shifts and move
    run_op("and", 3'b010, 1'b0, splat(16'h0081), splat(16'h0013), '0, splat(16'h0001));
    run_op("or",  3'b011, 1'b0, splat(16'h0081), splat(16'h0013), '0, splat(16'h0093));
    run_op("xor", 3'b100, 1'b0, splat(16'h0081), splat(16'h0013), '0, splat(16'h0092));
    run_op("shl", 3'b101, 1'b0, splat(16'h0081), splat(16'h0013), '0, splat(16'h0408));
    run_op("shr", 3'b110, 1'b0, splat(16'h0081), splat(16'h0013), '0, splat(16'h0010));
    run_op("mov", 3'b111, 1'b0, splat(16'h0081), splat(16'h0013), '0, splat(16'h0013));
    run_op("mov_imm", 3'b111, 1'b1, splat(16'h0081), splat(16'h0013), splat(16'hBEEF), splat(16'hBEEF));

    // Back-to-back with start held high; op changed mid-EXEC of the first op
    op = 3'b000; use_imm = 1'b0; src_a = splat(16'h0010); src_b = splat(16'h0003); start = 1'b1;
    @(posedge clk); #1;
    dones = 0; busys = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 2) op = 3'b001;
      if (busy_w[0]) busys++;
      if (done_w[0]) begin
        dones++;
        check_vec($sformatf("b2b.done_at%0d", c), c % 5, 0);
        if (c == 5)  check_vec("b2b.first_add", res_w[0], splat(16'h0013));
        if (c == 10) check_vec("b2b.second_sub", res_w[0], splat(16'h000D));
      end
    end
    start = 1'b0;
    check_vec("b2b.done_count", dones, 4);
    check_vec("b2b.busy_count", busys, 16);

    // Asynchronous reset while LPB=4 is on beat 2
    op = 3'b000; src_a = splat(16'h0100); src_b = splat(16'h0001); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("abort.busy_before", busy_w[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_vec($sformatf("abort.busy%0d", k), busy_w[k], 1'b0);
      check_vec($sformatf("abort.done%0d", k), done_w[k], 1'b0);
      check_vec($sformatf("abort.result%0d", k), res_w[k], '0);
    end
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_w != 3'b000) dones++;
    end
    check_vec("abort.no_done", dones, 0);
    run_op("after_abort_xor", 3'b100, 1'b0, splat(16'h1234), splat(16'h0F0F), '0, splat(16'h1D3B));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/vector_lane_alu_seq.md
Name: vector_lane_alu_seq

Overview:
- Multi-cycle vector execute stage. Sits directly downstream of the immediate extend unit and the vector register file read ports.
- Accepts two 16-lane operand vectors; operand B is either a register vector or the broadcast immediate vector.
- Computes an element-wise operation LPB lanes per clock, using a shared bank of LPB lane ALUs.
- Presents the full 16-lane result with a done pulse for the writeback stage.

Parameters:
- N, 16: lane width in bits.
- LPB, 4: lanes processed per beat. Legal values are 1, 2, 4, 8, 16. NBEATS = 16/LPB.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a vector operation; sampled on the rising edge.
- op  in  3  operation code, latched on accept.
- use_imm  in  1  1 selects imm_ext as operand B; 0 selects src_b. Latched on accept.
- src_a  in  [15:0][N-1:0]  operand A vector.
- src_b  in  [15:0][N-1:0]  register operand B vector.
- imm_ext  in  [15:0][N-1:0]  broadcast immediate vector from the extend unit.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result is valid and newly updated.
- result  out  [15:0][N-1:0]  last completed result vector.

Behaviour:
- Reset is asynchronous and active-low. Asserting rst_n low at any time, including mid-operation, forces:
  - state IDLE, beat counter 0
  - busy=0, done=0
  - result=0, staging=0, latched operands=0
  - The aborted operation produces no done.
- FSM states are IDLE, EXEC and DONE.
- Accept:
  - start=1 in IDLE or DONE is accepted on that edge.
  - On accept: latch src_a, the selected B vector (imm_ext or src_b) and op; beat=0; go to EXEC.
  - start in EXEC is ignored.
- EXEC:
  - Each edge computes lanes beat*LPB through beat*LPB+LPB-1 from the latched operands into the staging register, then beat increments.
  - On the edge computing beat NBEATS-1, result is loaded with the complete vector (staging plus final lanes), state goes to DONE, and beat clears.
- DONE:
  - Lasts one cycle: done=1, busy=0.
  - With no start, the next state is IDLE. With start=1, the operation is accepted and the next state is EXEC (back-to-back issue).
- Outputs are registered:
  - busy=1 exactly in EXEC cycles, i.e. NBEATS cycles after the accepting edge.
  - done=1 only in DONE. It is first visible after NBEATS edges following the accepting edge.
  - When LPB=16, EXEC lasts one cycle.
- result holds its previous value throughout EXEC. It changes only on entry to DONE. Downstream never sees partial lanes.
- Input changes after accept have no effect on the operation in flight.
- Per-lane op, with a = lane of A and b = lane of B. All arithmetic is unsigned modulo 2^N and carries never cross lanes:
  - 000: a+b
  - 001: a-b
  - 010: a&b
  - 011: a|b
  - 100: a^b
  - 101: a << b[3:0]
  - 110: a >> b[3:0], logical
  - 111: b (move/load-immediate)
  - Shift amount uses only the low 4 bits of b, irrespective of N.

Test Plan:
1. Reset then idle: rst_n low for 3 cycles, then release with start=0 -> busy=0, done=0, result all-zero lanes; no done ever appears.
2. Add with immediate: src_a lane i = i, imm_ext lanes = 0x0005, use_imm=1, op=000, one start pulse -> busy high 4 cycles, done one cycle; result lane i = i+5; result unchanged during busy.
3. Wrap and lane isolation: src_a lanes = 0xFFFF, src_b lanes = 0x0001, op=000 -> all lanes 0x0000. Then op=001 with src_a=0, src_b=1 -> all lanes 0xFFFF.
4. Shifts and move: src_a=0x0081, src_b=0x0013, op=101 -> 0x0408 (shift 3). op=110 -> 0x0010. op=111 -> 0x0013.
5. Back-to-back and ignored start: start held high continuously -> a new op accepted in every DONE cycle; start pulses during EXEC are ignored (exactly one done per 5 cycles with LPB=4). Inputs changed mid-EXEC do not alter the result.
6. Reset mid-operation: rst_n low during beat 2 -> busy, done and result are 0 immediately (asynchronously). After release, a fresh op completes in 4 busy cycles with a correct result. Repeat with LPB=1 (16 busy cycles) and LPB=16 (1 busy cycle).
